// File: rtl/gobang_move_sequencer_if.sv
// Signal bundle between the Gobang move sequencer and its environment
// (human input, board memory, chess-value evaluator, PS status registers).
interface gobang_move_sequencer_if;
    logic        start_game;
    logic        human_valid;
    logic [3:0]  human_i;
    logic [3:0]  human_j;
    logic        human_ready;
    logic [3:0]  cell_rd_i;
    logic [3:0]  cell_rd_j;
    logic        cell_occupied;
    logic        board_we;
    logic [3:0]  board_wr_i;
    logic [3:0]  board_wr_j;
    logic        board_wr_color;
    logic        eval_active;
    logic        eval_clr;
    logic        eval_done;
    logic [15:0] black_best_score;
    logic [15:0] white_best_score;
    logic [3:0]  black_best_i;
    logic [3:0]  black_best_j;
    logic [3:0]  white_best_i;
    logic [3:0]  white_best_j;
    logic        black_win;
    logic        white_win;
    logic        ai_move_valid;
    logic [3:0]  ai_i;
    logic [3:0]  ai_j;
    logic [7:0]  move_count;
    logic        game_over;
    logic [1:0]  winner;
    logic        err_illegal;
    logic        err_timeout;

    // sequencer side
    modport slave (
        input  start_game, human_valid, human_i, human_j, cell_occupied, eval_done,
               black_best_score, white_best_score, black_best_i, black_best_j,
               white_best_i, white_best_j, black_win, white_win,
        output human_ready, cell_rd_i, cell_rd_j, board_we, board_wr_i, board_wr_j,
               board_wr_color, eval_active, eval_clr, ai_move_valid, ai_i, ai_j,
               move_count, game_over, winner, err_illegal, err_timeout
    );

    // engine / environment side
    modport master (
        output start_game, human_valid, human_i, human_j, cell_occupied, eval_done,
               black_best_score, white_best_score, black_best_i, black_best_j,
               white_best_i, white_best_j, black_win, white_win,
        input  human_ready, cell_rd_i, cell_rd_j, board_we, board_wr_i, board_wr_j,
               board_wr_color, eval_active, eval_clr, ai_move_valid, ai_i, ai_j,
               move_count, game_over, winner, err_illegal, err_timeout
    );
endinterface

// File: rtl/gobang_move_sequencer.sv
// Turn-level controller: validates and writes human moves, runs one evaluator pass
// per move, picks the AI reply (attack or block) and reports win/draw/timeout.
module gobang_move_sequencer #(
    parameter int BOARD_SIZE     = 15,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                   clk,
    input  logic                   rst,
    gobang_move_sequencer_if.slave bus
);
    localparam logic [3:0]  EDGE_LIM = 4'(BOARD_SIZE);
    localparam logic [7:0]  CELLS    = 8'(BOARD_SIZE * BOARD_SIZE);
    localparam logic [11:0] TMO_LAST = 12'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, WAIT_HUMAN, CHECK_H, WRITE_H, EVAL_H, LATCH_H,
        DECIDE, WRITE_AI, EVAL_AI, LATCH_AI, OVER
    } state_t;

    state_t      state, state_nxt;

    logic [3:0]  hum_i, hum_j;
    logic [3:0]  blk_i, blk_j, wht_i, wht_j;
    logic        attack;
    logic        fallback;
    logic [11:0] tmo_cnt;
    logic [7:0]  move_cnt;
    logic [1:0]  winner_q;
    logic        err_tmo_q;
    logic        eval_clr_q;
    logic [3:0]  ai_i_q, ai_j_q;

    logic        in_eval, tmo_hit, hum_illegal, board_full, use_white;
    logic [3:0]  cand_i, cand_j;

    assign in_eval     = (state == EVAL_H) || (state == EVAL_AI);
    assign tmo_hit     = in_eval && !bus.eval_done && (tmo_cnt == TMO_LAST);
    assign hum_illegal = (hum_i >= EDGE_LIM) || (hum_j >= EDGE_LIM) || bus.cell_occupied;
    assign board_full  = (move_cnt == CELLS);
    // the second DECIDE cycle reads whichever candidate was not primary
    assign use_white   = attack ^ fallback;
    assign cand_i      = use_white ? wht_i : blk_i;
    assign cand_j      = use_white ? wht_j : blk_j;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = IDLE;
            WAIT_HUMAN: if (bus.human_valid) state_nxt = CHECK_H;
            CHECK_H:    state_nxt = hum_illegal ? WAIT_HUMAN : WRITE_H;
            WRITE_H:    state_nxt = EVAL_H;
            EVAL_H: begin
                if (bus.eval_done)  state_nxt = LATCH_H;
                else if (tmo_hit)   state_nxt = OVER;
            end
            LATCH_H:    state_nxt = (bus.black_win || board_full) ? OVER : DECIDE;
            DECIDE: begin
                if (!bus.cell_occupied) state_nxt = WRITE_AI;
                else if (fallback)      state_nxt = OVER;
            end
            WRITE_AI:   state_nxt = EVAL_AI;
            EVAL_AI: begin
                if (bus.eval_done)  state_nxt = LATCH_AI;
                else if (tmo_hit)   state_nxt = OVER;
            end
            LATCH_AI:   state_nxt = (bus.white_win || board_full) ? OVER : WAIT_HUMAN;
            OVER:       state_nxt = OVER;
            default:    state_nxt = IDLE;
        endcase
        // a new game aborts whatever is in progress
        if (bus.start_game) state_nxt = WAIT_HUMAN;
    end

    always_comb begin
        bus.human_ready    = 1'b0;
        bus.cell_rd_i      = 4'd0;
        bus.cell_rd_j      = 4'd0;
        bus.board_we       = 1'b0;
        bus.board_wr_i     = 4'd0;
        bus.board_wr_j     = 4'd0;
        bus.board_wr_color = 1'b0;
        bus.ai_move_valid  = 1'b0;
        bus.err_illegal    = 1'b0;
        bus.eval_active    = in_eval && (tmo_cnt == 12'd0);
        case (state)
            WAIT_HUMAN: bus.human_ready = 1'b1;
            CHECK_H: begin
                bus.cell_rd_i   = hum_i;
                bus.cell_rd_j   = hum_j;
                bus.err_illegal = hum_illegal;
            end
            WRITE_H: begin
                bus.board_we   = 1'b1;
                bus.board_wr_i = hum_i;
                bus.board_wr_j = hum_j;
            end
            DECIDE: begin
                bus.cell_rd_i = cand_i;
                bus.cell_rd_j = cand_j;
            end
            WRITE_AI: begin
                bus.board_we       = 1'b1;
                bus.board_wr_i     = ai_i_q;
                bus.board_wr_j     = ai_j_q;
                bus.board_wr_color = 1'b1;
                bus.ai_move_valid  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.eval_clr    = eval_clr_q;
    assign bus.ai_i        = ai_i_q;
    assign bus.ai_j        = ai_j_q;
    assign bus.move_count  = move_cnt;
    assign bus.game_over   = (state == OVER);
    assign bus.winner      = winner_q;
    assign bus.err_timeout = err_tmo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            move_cnt   <= 8'd0;
            winner_q   <= 2'b00;
            err_tmo_q  <= 1'b0;
            eval_clr_q <= 1'b0;
            ai_i_q     <= 4'd0;
            ai_j_q     <= 4'd0;
            fallback   <= 1'b0;
            tmo_cnt    <= 12'd0;
        end else begin
            eval_clr_q <= bus.start_game;
            tmo_cnt    <= in_eval ? tmo_cnt + 12'd1 : 12'd0;
            if (bus.start_game) begin
                move_cnt  <= 8'd0;
                winner_q  <= 2'b00;
                err_tmo_q <= 1'b0;
                ai_i_q    <= 4'd0;
                ai_j_q    <= 4'd0;
                fallback  <= 1'b0;
            end else begin
                case (state)
                    WRITE_H, WRITE_AI: if (!board_full) move_cnt <= move_cnt + 8'd1;
                    LATCH_H: begin
                        fallback <= 1'b0;
                        if (bus.black_win)   winner_q <= 2'b01;
                        else if (board_full) winner_q <= 2'b11;
                    end
                    DECIDE: begin
                        if (!bus.cell_occupied) begin
                            ai_i_q <= cand_i;
                            ai_j_q <= cand_j;
                        end else if (fallback) begin
                            winner_q <= 2'b00;
                        end else begin
                            fallback <= 1'b1;
                        end
                    end
                    LATCH_AI: begin
                        if (bus.white_win)   winner_q <= 2'b10;
                        else if (board_full) winner_q <= 2'b11;
                    end
                    default: ;
                endcase
                if (tmo_hit) begin
                    err_tmo_q <= 1'b1;
                    winner_q  <= 2'b00;
                end
            end
        end
    end

    // move coordinates and evaluator results need no reset: only read in the states that follow their capture
    always_ff @(posedge clk) begin
        if (state == WAIT_HUMAN && bus.human_valid) begin
            hum_i <= bus.human_i;
            hum_j <= bus.human_j;
        end
        if (state == LATCH_H) begin
            blk_i  <= bus.black_best_i;
            blk_j  <= bus.black_best_j;
            wht_i  <= bus.white_best_i;
            wht_j  <= bus.white_best_j;
            attack <= (bus.white_best_score >= bus.black_best_score);
        end
    end
endmodule

// File: tb/tb_gobang_move_sequencer.sv
// Randomized bench for gobang_move_sequencer: a board model plus turn-rule predictions
// checked against the DUT, with directed scenarios pinning literal outcomes.
`timescale 1ns/1ps
module tb_gobang_move_sequencer;
    localparam int BS  = 15;
    localparam int TMO = 4095;
    localparam int EV_AI = 1, EV_OVER = 2, EV_READY = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gobang_move_sequencer_if bus();

    gobang_move_sequencer #(.BOARD_SIZE(BS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic occ [0:15][0:15];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    // board memory model: cleared by eval_clr, filled by board_we
    always @(posedge clk) begin
        if (!rst || bus.eval_clr) begin
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) occ[a][b] <= 1'b0;
        end else if (bus.board_we) begin
            occ[bus.board_wr_i][bus.board_wr_j] <= 1'b1;
        end
    end
    assign bus.cell_occupied = occ[bus.cell_rd_i][bus.cell_rd_j];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int count_stones();
        int s = 0;
        for (int a = 0; a < BS; a++)
            for (int b = 0; b < BS; b++) s += int'(occ[a][b]);
        return s;
    endfunction

    // per-cycle rules: stone count, alternating colours, writes only to free cells
    always @(negedge clk) begin
        int s;
        if (chk_en && rst) begin
            s = count_stones();
            chk("move_count_vs_board", bus.move_count, s);
            chk("ready_and_over", bus.human_ready & bus.game_over, 0);
            chk("ai_valid_vs_we", bus.ai_move_valid, bus.board_we & bus.board_wr_color);
            if (bus.board_we) begin
                chk("we_target_free", occ[bus.board_wr_i][bus.board_wr_j], 0);
                chk("we_color_alternates", bus.board_wr_color, s % 2);
            end
            if (bus.ai_move_valid) begin
                chk("ai_i_vs_wr", bus.ai_i, bus.board_wr_i);
                chk("ai_j_vs_wr", bus.ai_j, bus.board_wr_j);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_game();
        chk_en = 1'b0;
        bus.start_game = 1'b1;
        tick();
        bus.start_game = 1'b0;
        chk("eval_clr_pulse", bus.eval_clr, 1);
        chk("ready_after_start", bus.human_ready, 1);
        chk("winner_cleared", bus.winner, 0);
        chk("over_cleared", bus.game_over, 0);
        chk("timeout_cleared", bus.err_timeout, 0);
        chk("count_cleared", bus.move_count, 0);
        tick();
        chk("eval_clr_once", bus.eval_clr, 0);
        chk_en = 1'b1;
    endtask

    // offers one human move; ends in the first EVAL cycle when accepted
    task automatic human(input logic [3:0] i, input logic [3:0] j, output bit ok);
        bit exp_ok;
        int w;
        exp_ok = (i < BS) && (j < BS) && !occ[i][j];
        w = 0;
        while (!bus.human_ready && w < 50) begin tick(); w++; end
        chk("human_ready_wait", w < 50, 1);
        bus.human_valid = 1'b1;
        bus.human_i = i;
        bus.human_j = j;
        tick();
        bus.human_valid = 1'b0;
        chk("err_illegal", bus.err_illegal, !exp_ok);
        chk("no_we_in_check", bus.board_we, 0);
        chk("not_ready_in_check", bus.human_ready, 0);
        tick();
        if (!exp_ok) begin
            chk("ready_after_reject", bus.human_ready, 1);
            chk("err_illegal_once", bus.err_illegal, 0);
            chk("no_we_after_reject", bus.board_we, 0);
        end else begin
            chk("human_we", bus.board_we, 1);
            chk("human_wr_i", bus.board_wr_i, i);
            chk("human_wr_j", bus.board_wr_j, j);
            chk("human_color", bus.board_wr_color, 0);
            tick();
            chk("eval_active_after_we", bus.eval_active, 1);
        end
        ok = exp_ok;
    endtask

    // answers an evaluator pass and checks the decision the turn rules require
    task automatic evaluate(input int dly, input bit after_ai,
                            input logic [15:0] bsc, input logic [3:0] bi, input logic [3:0] bj,
                            input logic [15:0] wsc, input logic [3:0] wi, input logic [3:0] wj,
                            input logic bw, input logic ww, output int ev);
        int s, exp_n, exp_ev, got_n, pi, pj, si, sj;
        logic [1:0] exp_win;
        for (int k = 0; k < dly; k++) begin
            tick();
            chk("eval_active_once", bus.eval_active, 0);
        end
        bus.eval_done = 1'b1;
        bus.black_best_score = bsc; bus.black_best_i = bi; bus.black_best_j = bj;
        bus.white_best_score = wsc; bus.white_best_i = wi; bus.white_best_j = wj;
        bus.black_win = bw; bus.white_win = ww;
        tick();
        bus.eval_done = 1'b0;
        s = count_stones();
        exp_win = 2'b00; pi = 0; pj = 0; exp_n = 1;
        if (after_ai ? ww : bw) begin
            exp_ev = EV_OVER; exp_win = after_ai ? 2'b10 : 2'b01;
        end else if (s == BS * BS) begin
            exp_ev = EV_OVER; exp_win = 2'b11;
        end else if (after_ai) begin
            exp_ev = EV_READY;
        end else begin
            if (wsc >= bsc) begin pi = wi; pj = wj; si = bi; sj = bj; end
            else            begin pi = bi; pj = bj; si = wi; sj = wj; end
            if (!occ[pi][pj])      begin exp_ev = EV_AI; exp_n = 2; end
            else if (!occ[si][sj]) begin exp_ev = EV_AI; exp_n = 3; pi = si; pj = sj; end
            else                   begin exp_ev = EV_OVER; exp_n = 3; end
        end
        got_n = -1;
        for (int n = 0; n <= 5 && got_n < 0; n++) begin
            if (n > 0) tick();
            if (bus.board_we || bus.game_over || bus.human_ready) got_n = n;
        end
        chk("decision_latency", got_n, exp_n);
        chk("no_timeout_flag", bus.err_timeout, 0);
        case (exp_ev)
            EV_AI: begin
                chk("ai_we", bus.board_we, 1);
                chk("ai_color", bus.board_wr_color, 1);
                chk("ai_move_valid", bus.ai_move_valid, 1);
                chk("ai_wr_i", bus.board_wr_i, pi);
                chk("ai_wr_j", bus.board_wr_j, pj);
                chk("ai_i", bus.ai_i, pi);
                chk("ai_j", bus.ai_j, pj);
            end
            EV_OVER: begin
                chk("game_over", bus.game_over, 1);
                chk("winner", bus.winner, exp_win);
                chk("no_we_at_over", bus.board_we, 0);
                tick();
                chk("over_held", bus.game_over, 1);
                chk("ready_low_in_over", bus.human_ready, 0);
            end
            default: chk("ready_next_turn", bus.human_ready, 1);
        endcase
        ev = exp_ev;
    endtask

    task automatic pick_move(output logic [3:0] i, output logic [3:0] j);
        int r, tries;
        r = $urandom_range(0, 9);
        i = 4'd15; j = 4'd15;
        if (r == 0) begin
            i = 4'($urandom_range(0, 15)); j = 4'd15;
            if ($urandom_range(0, 1) == 1) begin j = i; i = 4'd15; end
        end else if (r == 1) begin
            for (tries = 0; tries < 2000; tries++) begin
                i = 4'($urandom_range(0, 14)); j = 4'($urandom_range(0, 14));
                if (occ[i][j]) break;
            end
        end else begin
            for (tries = 0; tries < 2000; tries++) begin
                i = 4'($urandom_range(0, 14)); j = 4'($urandom_range(0, 14));
                if (!occ[i][j]) break;
            end
        end
    endtask

    task automatic first_free(output logic [3:0] i, output logic [3:0] j);
        bit found = 1'b0;
        i = 4'd0; j = 4'd0;
        for (int a = 0; a < BS && !found; a++)
            for (int b = 0; b < BS && !found; b++)
                if (!occ[a][b]) begin i = 4'(a); j = 4'(b); found = 1'b1; end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish, %0d checks made", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int ev, n;
        logic [3:0] hi, hj, fi, fj;
        logic [15:0] bsc, wsc;
        bus.start_game = 0; bus.human_valid = 0; bus.human_i = 0; bus.human_j = 0;
        bus.eval_done = 0; bus.black_best_score = 0; bus.white_best_score = 0;
        bus.black_best_i = 0; bus.black_best_j = 0; bus.white_best_i = 0; bus.white_best_j = 0;
        bus.black_win = 0; bus.white_win = 0;

        #12;
        chk("reset_outputs_a", {bus.human_ready, bus.cell_rd_i, bus.cell_rd_j, bus.board_we,
                                bus.board_wr_i, bus.board_wr_j, bus.board_wr_color, bus.eval_active}, 0);
        chk("reset_outputs_b", {bus.eval_clr, bus.ai_move_valid, bus.ai_i, bus.ai_j, bus.move_count,
                                bus.game_over, bus.winner, bus.err_illegal, bus.err_timeout}, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("idle_not_ready", bus.human_ready, 0);

        // stray eval_done while waiting for a human is ignored
        new_game();
        bus.eval_done = 1'b1;
        tick();
        bus.eval_done = 1'b0;
        chk("stray_done_ready", bus.human_ready, 1);
        chk("stray_done_no_active", bus.eval_active, 0);

        // reset arriving in the middle of an evaluation
        human(4'd7, 4'd7, ok);
        tick(); tick();
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("midreset_outputs_a", {bus.human_ready, bus.cell_rd_i, bus.cell_rd_j, bus.board_we,
                                   bus.board_wr_i, bus.board_wr_j, bus.board_wr_color, bus.eval_active}, 0);
        chk("midreset_outputs_b", {bus.eval_clr, bus.ai_move_valid, bus.ai_i, bus.ai_j, bus.move_count,
                                   bus.game_over, bus.winner, bus.err_illegal, bus.err_timeout}, 0);
        tick();
        rst = 1'b1;
        tick();

        // block: black threat outscores white attack
        new_game();
        human(4'd7, 4'd7, ok);
        evaluate(5, 1'b0, 16'd216, 4'd6, 4'd6, 16'd36, 4'd7, 4'd8, 1'b0, 1'b0, ev);
        chk("block_ai_i", bus.ai_i, 6);
        chk("block_ai_j", bus.ai_j, 6);
        chk("block_color", bus.board_wr_color, 1);
        tick();
        chk("block_move_count", bus.move_count, 2);
        evaluate(3, 1'b1, 16'd0, 4'd0, 4'd0, 16'd0, 4'd0, 4'd0, 1'b0, 1'b0, ev);

        // illegal moves: column 15, then occupied cells
        human(4'd3, 4'd15, ok);
        human(4'd7, 4'd7, ok);
        human(4'd6, 4'd6, ok);
        chk("illegal_count_kept", bus.move_count, 2);

        // primary (white attack) occupied, black candidate free: fallback
        human(4'd8, 4'd8, ok);
        evaluate(2, 1'b0, 16'd100, 4'd9, 4'd9, 16'd500, 4'd7, 4'd7, 1'b0, 1'b0, ev);
        chk("fallback_ai_i", bus.ai_i, 9);
        tick();
        evaluate(0, 1'b1, 16'd0, 4'd0, 4'd0, 16'd0, 4'd0, 4'd0, 1'b0, 1'b0, ev);

        // both candidates occupied: abort with no winner
        human(4'd5, 4'd5, ok);
        evaluate(1, 1'b0, 16'd20, 4'd6, 4'd6, 16'd10, 4'd7, 4'd7, 1'b0, 1'b0, ev);
        chk("both_occ_winner", bus.winner, 0);

        // black wins on its move
        new_game();
        human(4'd7, 4'd7, ok);
        evaluate(4, 1'b0, 16'd9999, 4'd7, 4'd8, 16'd5, 4'd1, 4'd1, 1'b1, 1'b0, ev);
        chk("black_win_winner", bus.winner, 2'b01);
        chk("black_win_count", bus.move_count, 1);

        // equal scores attack; white then wins
        new_game();
        human(4'd2, 4'd3, ok);
        evaluate(2, 1'b0, 16'd50, 4'd2, 4'd2, 16'd50, 4'd1, 4'd1, 1'b0, 1'b0, ev);
        chk("tie_attack_ai_i", bus.ai_i, 1);
        tick();
        evaluate(6, 1'b1, 16'd0, 4'd0, 4'd0, 16'd0, 4'd0, 4'd0, 1'b0, 1'b1, ev);
        chk("white_win_winner", bus.winner, 2'b10);

        // evaluator never answers
        new_game();
        human(4'd0, 4'd0, ok);
        n = 0;
        while (!bus.game_over && n < TMO + 20) begin tick(); n++; end
        chk("timeout_latency", n, TMO);
        chk("timeout_flag", bus.err_timeout, 1);
        chk("timeout_winner", bus.winner, 0);
        tick();
        chk("timeout_sticky", bus.err_timeout, 1);
        new_game();

        // randomized games
        for (int g = 0; g < 6; g++) begin
            new_game();
            for (int m = 0; m < 40; m++) begin
                pick_move(hi, hj);
                human(hi, hj, ok);
                if (!ok) continue;
                bsc = 16'($urandom_range(0, 1000));
                wsc = ($urandom_range(0, 3) == 0) ? bsc : 16'($urandom_range(0, 1000));
                evaluate($urandom_range(0, 30), 1'b0, bsc,
                         4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)), wsc,
                         4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)),
                         1'($urandom_range(0, 19) == 0), 1'b0, ev);
                if (ev != EV_AI) break;
                tick();
                chk("eval_active_after_ai", bus.eval_active, 1);
                evaluate($urandom_range(0, 30), 1'b1, 16'd0, 4'd0, 4'd0, 16'd0, 4'd0, 4'd0,
                         1'b0, 1'($urandom_range(0, 19) == 0), ev);
                if (ev != EV_READY) break;
            end
        end

        // fill the whole board: the 225th stone is black's and ends in a draw
        new_game();
        ev = EV_READY;
        for (int m = 0; m < 130 && ev == EV_READY; m++) begin
            first_free(hi, hj);
            human(hi, hj, ok);
            first_free(fi, fj);
            evaluate(0, 1'b0, 16'd1, fi, fj, 16'd1, fi, fj, 1'b0, 1'b0, ev);
            if (ev != EV_AI) break;
            tick();
            evaluate(0, 1'b1, 16'd0, 4'd0, 4'd0, 16'd0, 4'd0, 4'd0, 1'b0, 1'b0, ev);
        end
        chk("draw_winner", bus.winner, 2'b11);
        chk("draw_count", bus.move_count, 225);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/gobang_move_sequencer.md
# gobang_move_sequencer

Turn-level controller for the Gobang engine. It accepts human (black) moves over a valid/ready handshake and checks their legality against the board memory, then writes them. After each move it runs one full-board pass of the chess-value evaluator and decides the AI (white) reply, attack or block. It also detects win/draw/timeout and reports game status to the PS-facing register block.

## Interface
- BOARD_SIZE, 15, board edge length; legal coordinates 0..BOARD_SIZE-1
- TIMEOUT_CYCLES, 4095, max cycles to wait for eval_done per evaluation (12-bit counter)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start_game  in  1  one-cycle pulse; (re)starts a game from any state
- human_valid  in  1  human move offered
- human_i, human_j  in  4 each  human move row/column
- human_ready  out  1  high only in WAIT_HUMAN
- cell_rd_i, cell_rd_j  out  4 each  board read address
- cell_occupied  in  1  combinational board read data for cell_rd_*
- board_we  out  1  one-cycle board write strobe
- board_wr_i, board_wr_j  out  4 each  write address
- board_wr_color  out  1  0 = black, 1 = white
- eval_active  out  1  one-cycle evaluator start pulse
- eval_clr  out  1  one-cycle evaluator clear pulse
- eval_done  in  1  evaluator data_valued pulse
- black_best_score, white_best_score  in  16 each  evaluator best scores
- black_best_i/j, white_best_i/j  in  4 each  evaluator best cells
- black_win, white_win  in  1 each  evaluator win flags
- ai_move_valid  out  1  one-cycle pulse with ai_i/ai_j
- ai_i, ai_j  out  4 each  last AI move (held)
- move_count  out  8  stones placed this game
- game_over  out  1  held high in OVER
- winner  out  2  00 none/abort, 01 black, 10 white, 11 draw
- err_illegal  out  1  one-cycle pulse on rejected human move
- err_timeout  out  1  sticky until start_game

## Operation
- States: IDLE, WAIT_HUMAN, CHECK_H, WRITE_H, EVAL_H, LATCH_H, DECIDE, WRITE_AI, EVAL_AI, LATCH_AI, OVER.
- IDLE: on start_game, pulse eval_clr, clear move_count/winner/err_timeout/ai_i/ai_j, go WAIT_HUMAN. start_game in any other state does the same (abort current game).
- WAIT_HUMAN: human_ready=1; on human_valid&human_ready latch coordinates, go CHECK_H.
- CHECK_H: cell_rd_* = latched cell. If i or j >= BOARD_SIZE, or cell_occupied, pulse err_illegal and return to WAIT_HUMAN. Otherwise go WRITE_H.
- WRITE_H: board_we=1, color 0; move_count+1; go EVAL_H.
- EVAL_H/EVAL_AI: eval_active pulsed on the first cycle only; wait for eval_done. Evaluator result registers update on the eval_done cycle, so go LATCH_* and sample all evaluator inputs there.
- LATCH_H: black_win → OVER, winner=01. Else if move_count==BOARD_SIZE² → OVER, winner=11. Else go DECIDE.
- DECIDE, two cycles:
  - Cycle 1 reads the primary candidate. Primary = white_best cell if white_best_score >= black_best_score (attack), else black_best cell (block).
  - If the primary is free, commit it. Else cycle 2 reads the other candidate and commits it if free. If both are occupied → OVER, winner=00.
- WRITE_AI: board_we=1, color 1; ai_i/ai_j updated; ai_move_valid pulse; move_count+1; go EVAL_AI.
- LATCH_AI: white_win → OVER, winner=10. Else if move_count==BOARD_SIZE² → OVER, winner=11. Else go WAIT_HUMAN.
- OVER: game_over=1; stays until start_game.
- Timeout: a counter is cleared on entering EVAL_*. If it reaches TIMEOUT_CYCLES without eval_done: set err_timeout, go OVER, winner=00.
- eval_done outside EVAL_* is ignored.

## Timing
- Reset values: all outputs 0, state IDLE.
- human_valid&ready handshake to board_we: 2 cycles (CHECK_H, WRITE_H).
- eval_active is asserted the cycle after board_we.
- eval_done to the LATCH decision: 1 cycle.
- LATCH_H to board_we (AI move): 2 cycles (primary free) or 3 cycles (fallback).
- Evaluator pass is about 225×7 cycles, which fits within TIMEOUT_CYCLES.
- move_count saturates at 225; no wrap.
- Coordinates are 4-bit; value 15 is always illegal.

## Test plan
- Reset mid-EVAL_H → all outputs 0 immediately; then start_game pulses eval_clr, and human_ready=1 on the following cycle.
- Human (7,7), evaluator returns white 36@(7,8), black 216@(6,6) → AI blocks: ai_i=6, ai_j=6, board_wr_color=1, move_count=2.
- Human (3,15), then human to an occupied cell → err_illegal pulses, no board_we, back to WAIT_HUMAN each time.
- Evaluator returns black_win=1 after a human move → winner=01, game_over=1, no AI write, human_ready stays 0.
- Primary candidate occupied, secondary free → AI plays secondary in 3 cycles; both occupied → winner=00, game_over.
- eval_done withheld → err_timeout=1 and game_over after exactly TIMEOUT_CYCLES; start_game clears both.
